// File: rtl/fifo_access_scheduler_if.sv
// Bundle of requester-side and FIFO-side signals of fifo_access_scheduler.
//   slave  : the scheduler (drives acks, FIFO strobes, level, rd_valid/rd_data)
//   master : the surroundings (requesters plus the FIFO itself)
interface fifo_access_scheduler_if #(
    parameter int NUM_WR     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_WR-1:0]            wr_req;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_ack;
    logic                         rd_req;
    logic                         rd_ack;
    logic                         rd_valid;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic [LW-1:0]                level;
    logic                         fifo_wr_en;
    logic [DATA_WIDTH-1:0]        fifo_data_in;
    logic                         fifo_rd_en;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DATA_WIDTH-1:0]        fifo_data_out;

    modport slave (
        input  wr_req, wr_data, rd_req, fifo_full, fifo_empty, fifo_data_out,
        output wr_ack, rd_ack, rd_valid, rd_data, level,
               fifo_wr_en, fifo_data_in, fifo_rd_en
    );

    modport master (
        output wr_req, wr_data, rd_req, fifo_full, fifo_empty, fifo_data_out,
        input  wr_ack, rd_ack, rd_valid, rd_data, level,
               fifo_wr_en, fifo_data_in, fifo_rd_en
    );
endinterface

// File: rtl/fifo_access_scheduler.sv
// fifo_access_scheduler
// Shares one FIFO write port and one read port between NUM_WR writers and a
// single reader. At most one FIFO operation is issued per cycle. Writers are
// served round-robin; write-vs-read contention is settled by a priority bit
// that flips after BURST consecutive contended grants to one side. Tracks
// FIFO occupancy in `level`.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high (shared with the FIFO)
//   bus   : requester handshakes, FIFO strobes/flags, level (slave modport)
module fifo_access_scheduler #(
    parameter int NUM_WR     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int BURST      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    fifo_access_scheduler_if.slave   bus
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BURST + 1);
    localparam int PW = $clog2(NUM_WR);

    localparam logic [0:0] PRI_WR = 1'b0;
    localparam logic [0:0] PRI_RD = 1'b1;

    logic [PW-1:0] last_wr_q, last_wr_d;
    logic [0:0]    pri_q, pri_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic          rd_valid_q, rd_valid_d;

    logic [PW-1:0] cand;
    logic          wr_elig, rd_elig, contend;
    logic          do_wr, do_rd;
    logic [NUM_WR-1:0]     wr_ack_c;
    logic [DATA_WIDTH-1:0] data_in_c;

    // Round-robin candidate: first requester strictly after last_wr, wrapping.
    always_comb begin
        int idx;
        logic found;
        cand  = last_wr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_WR; k++) begin
            idx = (int'(last_wr_q) + k) % NUM_WR;
            if (!found && bus.wr_req[idx]) begin
                cand  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign wr_elig = (|bus.wr_req) & ~bus.fifo_full;
    assign rd_elig = bus.rd_req & ~bus.fifo_empty;
    assign contend = wr_elig & rd_elig;

    // Strobes are gated by reset so nothing is acked while reset is held.
    assign do_wr = ~reset & wr_elig & (~rd_elig | (pri_q == PRI_WR));
    assign do_rd = ~reset & rd_elig & (~wr_elig | (pri_q == PRI_RD));

    always_comb begin
        wr_ack_c  = '0;
        data_in_c = '0;
        if (do_wr) begin
            wr_ack_c[cand] = 1'b1;
            data_in_c      = bus.wr_data[cand*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        last_wr_d   = do_wr ? cand : last_wr_q;
        pri_d       = pri_q;
        burst_cnt_d = burst_cnt_q;
        // Only contended grants consume the burst budget; the count reaching
        // BURST flips priority and restarts the count on the same edge.
        if (contend) begin
            if (burst_cnt_q == BW'(BURST - 1)) begin
                pri_d       = ~pri_q;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
        level_d = level_q;
        if (do_wr)      level_d = level_q + 1'b1;
        else if (do_rd) level_d = level_q - 1'b1;
        rd_valid_d = do_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_wr_q   <= PW'(NUM_WR - 1);
            pri_q       <= PRI_WR;
            burst_cnt_q <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            last_wr_q   <= last_wr_d;
            pri_q       <= pri_d;
            burst_cnt_q <= burst_cnt_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.wr_ack       = wr_ack_c;
    assign bus.fifo_wr_en   = do_wr;
    assign bus.fifo_data_in = data_in_c;
    assign bus.fifo_rd_en   = do_rd;
    assign bus.rd_ack       = do_rd;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = bus.fifo_data_out;
    assign bus.level        = level_q;

    a_one_op: assert property (@(posedge clk) disable iff (reset)
        !(bus.fifo_wr_en && bus.fifo_rd_en));
    a_empty: assert property (@(posedge clk) disable iff (reset)
        ((level_q == '0) == bus.fifo_empty));
    a_full: assert property (@(posedge clk) disable iff (reset)
        ((level_q == LW'(FIFO_DEPTH)) == bus.fifo_full));
endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a behavioural 32-word FIFO.
module tb_fifo_access_scheduler;
    localparam int NW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_access_scheduler_if #(.NUM_WR(NW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    fifo_access_scheduler #(.NUM_WR(NW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural FIFO: no operation when both enables are high.
    logic [DW-1:0] mem [DEPTH];
    int cnt, wp, rp;
    logic [DW-1:0] dout;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0; wp <= 0; rp <= 0; dout <= '0;
        end else if (bus.fifo_wr_en && !bus.fifo_rd_en && cnt < DEPTH) begin
            mem[wp] <= bus.fifo_data_in;
            wp <= (wp + 1) % DEPTH;
            cnt <= cnt + 1;
        end else if (bus.fifo_rd_en && !bus.fifo_wr_en && cnt > 0) begin
            dout <= mem[rp];
            rp <= (rp + 1) % DEPTH;
            cnt <= cnt - 1;
        end
    end
    always_comb begin
        bus.fifo_full     = (cnt == DEPTH);
        bus.fifo_empty    = (cnt == 0);
        bus.fifo_data_out = dout;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_ack;
        logic       exp_w;
        int         exp_lvl;

        reset = 1'b1;
        bus.wr_req = 4'hF;
        bus.rd_req = 1'b1;
        for (int i = 0; i < NW; i++) bus.wr_data[i*DW +: DW] = 8'h10 + 8'(i);

        // Requests held during reset must not be acked.
        repeat (3) begin
            @(negedge clk);
            chk("rst_wr_ack", 32'(bus.wr_ack), 32'h0);
            chk("rst_strobes", 32'({bus.rd_ack, bus.fifo_wr_en, bus.fifo_rd_en, bus.rd_valid}), 32'h0);
            chk("rst_level", 32'(bus.level), 32'h0);
            tick();
        end
        reset = 1'b0;
        bus.wr_req = '0;
        bus.rd_req = 1'b0;

        // Idle after reset.
        repeat (10) begin
            @(negedge clk);
            chk("idle_out", 32'({bus.wr_ack, bus.rd_ack, bus.fifo_wr_en, bus.fifo_rd_en,
                                 bus.rd_valid, bus.fifo_data_in}), 32'h0);
            chk("idle_level", 32'(bus.level), 32'h0);
            tick();
        end

        // All four writers, fill to full.
        bus.wr_req = 4'hF;
        for (int k = 0; k < DEPTH; k++) begin
            e_ack = 4'b0001 << (k % 4);
            @(negedge clk);
            chk("fill_ack", 32'(bus.wr_ack), 32'(e_ack));
            chk("fill_din", 32'(bus.fifo_data_in), 32'(8'h10 + 8'(k % 4)));
            chk("fill_level", 32'(bus.level), 32'(k));
            tick();
        end
        repeat (3) begin
            @(negedge clk);
            chk("full_ack", 32'(bus.wr_ack), 32'h0);
            chk("full_wr_en", 32'(bus.fifo_wr_en), 32'h0);
            chk("full_level", 32'(bus.level), 32'd32);
            tick();
        end

        // Burst-limited contention: preload 8 words, then writer 2 vs reader.
        do_reset();
        bus.wr_req = 4'b0001;
        repeat (8) tick();
        bus.wr_req = 4'b0100;
        bus.rd_req = 1'b1;
        exp_lvl = 8;
        for (int j = 0; j < 16; j++) begin
            exp_w = ((j / 4) % 2) == 0;
            @(negedge clk);
            chk("burst_wr_en", 32'(bus.fifo_wr_en), 32'(exp_w));
            chk("burst_rd_en", 32'(bus.fifo_rd_en), 32'(!exp_w));
            chk("burst_ack", 32'(bus.wr_ack), exp_w ? 32'h4 : 32'h0);
            chk("burst_level", 32'(bus.level), 32'(exp_lvl));
            exp_lvl = exp_w ? exp_lvl + 1 : exp_lvl - 1;
            tick();
        end

        // Write 0xA5 then read it back.
        do_reset();
        bus.wr_data[7:0] = 8'hA5;
        bus.wr_req = 4'b0001;
        @(negedge clk);
        chk("a5_wr_ack", 32'(bus.wr_ack), 32'h1);
        chk("a5_din", 32'(bus.fifo_data_in), 32'hA5);
        tick();
        bus.wr_req = '0;
        bus.rd_req = 1'b1;
        @(negedge clk);
        chk("a5_rd_ack", 32'(bus.rd_ack), 32'h1);
        chk("a5_level1", 32'(bus.level), 32'h1);
        chk("a5_vld_early", 32'(bus.rd_valid), 32'h0);
        tick();
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("a5_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("a5_rd_data", 32'(bus.rd_data), 32'hA5);
        chk("a5_level0", 32'(bus.level), 32'h0);
        chk("a5_rd_ack_off", 32'(bus.rd_ack), 32'h0);
        tick();
        @(negedge clk);
        chk("a5_vld_off", 32'(bus.rd_valid), 32'h0);
        tick();

        // Round-robin pointer.
        do_reset();
        bus.wr_req = 4'b0010;
        @(negedge clk);
        chk("rr_first", 32'(bus.wr_ack), 32'h2);
        tick();
        bus.wr_req = 4'b1010;
        @(negedge clk);
        chk("rr_second", 32'(bus.wr_ack), 32'h8);
        tick();
        @(negedge clk);
        chk("rr_third", 32'(bus.wr_ack), 32'h2);
        tick();
        bus.wr_req = '0;

        // Reset right after a read: clears rd_valid, level and priority.
        do_reset();
        bus.wr_req = 4'b0001;
        tick();
        bus.rd_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("pre_wr_burst", 32'(bus.fifo_wr_en), 32'h1);
            tick();
        end
        @(negedge clk);
        chk("pre_rd_win", 32'(bus.rd_ack), 32'h1);
        chk("pre_rd_noack", 32'(bus.wr_ack), 32'h0);
        tick();
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", 32'(bus.rd_valid), 32'h0);
        chk("mid_rst_level", 32'(bus.level), 32'h0);
        tick();
        reset = 1'b0;
        bus.wr_req = 4'b0001;
        tick();
        bus.rd_req = 1'b1;
        @(negedge clk);
        chk("post_rst_wr", 32'(bus.fifo_wr_en), 32'h1);
        chk("post_rst_rd", 32'(bus.fifo_rd_en), 32'h0);
        tick();
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_access_scheduler.md
# fifo_access_scheduler

Shares the single write port and single read port of the team's synchronous FIFO between NUM_WR write requesters and one read requester. Per cycle it issues at most one FIFO operation, either one write or one read, never both, because the FIFO performs no operation when both enables are high. Writers are served round-robin. Contention between the write side and the read side is resolved by a burst-limited priority state machine. The block also tracks FIFO occupancy for upstream flow control.

## Interface
- NUM_WR, 4, number of write requesters (2..8)
- DATA_WIDTH, 8, FIFO word width
- FIFO_DEPTH, 32, FIFO capacity in words; sets `level` width
- BURST, 4, maximum consecutive contended operations granted to one side before priority flips (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; shared with the FIFO
- wr_req  in  NUM_WR  per-writer request; level; held with data until acked
- wr_data  in  NUM_WR*DATA_WIDTH  writer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_ack  out  NUM_WR  one-hot; writer's word is written at this clock edge
- rd_req  in  1  reader request; level
- rd_ack  out  1  read issued this cycle
- rd_valid  out  1  rd_data valid; one cycle after rd_ack
- rd_data  out  DATA_WIDTH  passthrough of fifo_data_out
- level  out  $clog2(FIFO_DEPTH+1)  words currently stored
- fifo_wr_en  out  1  to FIFO write enable
- fifo_data_in  out  DATA_WIDTH  to FIFO write data
- fifo_rd_en  out  1  to FIFO read enable
- fifo_full  in  1  from FIFO
- fifo_empty  in  1  from FIFO
- fifo_data_out  in  DATA_WIDTH  from FIFO; registered there

## Operation
- Eligibility:
  - wr_elig = |wr_req & ~fifo_full
  - rd_elig = rd_req & ~fifo_empty
- Writer select uses a round-robin pointer `last_wr` (reset NUM_WR-1).
  - The candidate is the first requesting index after `last_wr`, searching upward and wrapping.
  - `last_wr` updates to the candidate only when a write issues.
- Side select comes from register `pri` ∈ {PRI_WR, PRI_RD}, reset PRI_WR, and counter `burst_cnt`, reset 0, width $clog2(BURST+1).
  - Only wr_elig: write issues; pri and burst_cnt unchanged.
  - Only rd_elig: read issues; pri and burst_cnt unchanged.
  - Both eligible: the pri side issues and burst_cnt increments. When burst_cnt reaches BURST, pri flips and burst_cnt clears in the same edge.
  - Neither eligible: idle; state unchanged.
- Write issue: all of the following occur in the same cycle, combinationally.
  - fifo_wr_en = 1
  - fifo_data_in = candidate's wr_data slice
  - wr_ack[candidate] = 1
- Read issue: fifo_rd_en = 1 and rd_ack = 1 in the same cycle, combinationally. rd_valid is registered, high the next cycle.
- fifo_wr_en and fifo_rd_en are never high together (invariant).
- level: +1 on a write issue, −1 on a read issue, saturating is never required. level == 0 iff fifo_empty, and level == FIFO_DEPTH iff fifo_full (assertion).
- fifo_data_in = 0 when no write issues.

## Timing
- Reset values:
  - wr_ack = 0, rd_ack = 0, fifo_wr_en = 0, fifo_rd_en = 0 (combinational outputs forced 0 while reset is high)
  - rd_valid = 0, level = 0
  - pri = PRI_WR, burst_cnt = 0, last_wr = NUM_WR-1
- Arbitration latency is 0 cycles: a request seen at edge-setup is acked in that cycle if it wins.
- The FIFO updates its pointers at the edge. Its flags are therefore correct for the next cycle's decision, so no lookahead is needed.
- Write into a full FIFO never issues. Read from an empty FIFO never issues.
- Write and read when level == FIFO_DEPTH-1:
  - The write issues only if it wins arbitration.
  - If the write wins, the FIFO is full next cycle and writes stall.
- Reset mid-operation:
  - A pending rd_valid is cleared.
  - Requesters must re-present their requests after reset.
  - No ack appears during reset.
- Requester drops wr_req before ack: no write for that requester. The pointer does not advance.

## Test plan
- Reset, then 10 idle cycles → all outputs 0, level = 0, no FIFO strobes.
- Writers 0..3 request continuously with data 0x10+i, FIFO empty, rd_req = 0 → acks 0,1,2,3,0,... one per cycle. level reaches 32 after 32 cycles, then wr_ack stays 0 while fifo_full = 1.
- FIFO holds 8 words, rd_req = 1 and writer 2 requesting constantly, BURST = 4 → pattern W,W,W,W,R,R,R,R,W,...; fifo_wr_en & fifo_rd_en never both high; level changes by ±1 per cycle.
- Write 0xA5 then read with no contention → rd_ack in cycle t, rd_valid = 1 and rd_data = 0xA5 in cycle t+1.
- Only writer 1 requests, then writers 1 and 3 request together → writer 1 is acked first; the next contended cycle grants writer 3, not writer 1.
- Assert reset in the cycle after rd_ack → rd_valid = 0, level = 0, pri = PRI_WR. The first post-reset contended cycle grants the write side.
